// File: rtl/sweep_pkg.sv
// Shared encodings for the pattern sweep generator: sequence modes and FSM states.
package sweep_pkg;

  localparam logic [1:0] MODE_BIN_UP = 2'b00;
  localparam logic [1:0] MODE_GRAY   = 2'b01;
  localparam logic [1:0] MODE_BIN_DN = 2'b10;
  localparam logic [1:0] MODE_WALK1  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sweep_encode.sv
// Combinational mapping from sweep ordinal and mode to the stimulus vector.
module sweep_encode
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] index_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] pattern_o
);

  always_comb begin
    pattern_o = '0;
    case (mode_i)
      MODE_BIN_UP: pattern_o = index_i;
      MODE_GRAY:   pattern_o = index_i ^ (index_i >> 1);
      MODE_BIN_DN: pattern_o = ~index_i;
      MODE_WALK1:  pattern_o = WIDTH'(1) << index_i;
      default:     pattern_o = '0;
    endcase
  end

endmodule

// File: rtl/pattern_sweep.sv
// Sweep FSM: steps an ordinal through a mode-selected sequence, holding each
// vector for DWELL un-held cycles, with abort and hold control.
module pattern_sweep
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] index,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(DWELL + 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
  localparam logic [WIDTH-1:0] WalkLast = WIDTH'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [CntW-1:0]  dwell_q, dwell_d;
  logic [WIDTH-1:0] last_idx;
  logic [WIDTH-1:0] enc_pattern;

  // Direct compare against N-1 so a full-width index never needs to wrap.
  assign last_idx = (mode_q == MODE_WALK1) ? WalkLast : '1;

  // Encode the next-state ordinal so pattern and index land on the same edge.
  sweep_encode #(
    .WIDTH(WIDTH)
  ) u_encode (
    .index_i  (index_d),
    .mode_i   (mode_d),
    .pattern_o(enc_pattern)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    index_d = index_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          mode_d  = mode;
          index_d = '0;
          dwell_d = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          index_d = '0;
          dwell_d = '0;
        end else if (!hold) begin
          if (dwell_q == DwellLast) begin
            dwell_d = '0;
            if (index_q == last_idx) begin
              state_d = ST_DONE;
              index_d = '0;
            end else begin
              index_d = index_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        index_d = '0;
        dwell_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        index_d = '0;
        dwell_d = '0;
      end
    endcase
    pattern_d = (state_d == ST_RUN) ? enc_pattern : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_BIN_UP;
      index_q   <= '0;
      pattern_q <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      index_q   <= index_d;
      pattern_q <= pattern_d;
      dwell_q   <= dwell_d;
    end
  end

  assign pattern = pattern_q;
  assign index   = index_q;
  assign valid   = (state_q == ST_RUN);
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_sweep.sv
// Directed bench for pattern_sweep: three WIDTH=3 instances with DWELL 2, 1 and 3.
module tb_pattern_sweep;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       hold;
  logic [1:0] mode;

  logic [2:0] pat_a, idx_a, pat_b, idx_b, pat_c, idx_c;
  logic       val_a, bsy_a, dn_a, val_b, bsy_b, dn_b, val_c, bsy_c, dn_c;

  int n_total;
  int n_bad;

  pattern_sweep #(.WIDTH(3), .DWELL(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold), .mode(mode),
    .pattern(pat_a), .index(idx_a), .valid(val_a), .busy(bsy_a), .done(dn_a)
  );

  pattern_sweep #(.WIDTH(3), .DWELL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold), .mode(mode),
    .pattern(pat_b), .index(idx_b), .valid(val_b), .busy(bsy_b), .done(dn_b)
  );

  pattern_sweep #(.WIDTH(3), .DWELL(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold), .mode(mode),
    .pattern(pat_c), .index(idx_c), .valid(val_c), .busy(bsy_c), .done(dn_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [2:0] gray_tab [8];
  logic [2:0] walk_tab [3];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    hold  = 1'b0;
    mode  = 2'b00;
    gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    walk_tab = '{3'b001, 3'b010, 3'b100};

    // Reset state, checked while clock runs under reset.
    #13;
    check_eq("rst_pattern", pat_a, 0);
    check_eq("rst_index", idx_a, 0);
    check_eq("rst_valid", val_a, 0);
    check_eq("rst_busy", bsy_a, 0);
    check_eq("rst_done", dn_a, 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", bsy_a, 0);

    // Binary ascending, DWELL=2: 0..7 each two cycles, then one done pulse.
    pulse_start(2'b00);
    for (int k = 0; k < 16; k++) begin
      check_eq("up_pattern", pat_a, k / 2);
      check_eq("up_index", idx_a, k / 2);
      check_eq("up_valid", val_a, 1);
      check_eq("up_busy", bsy_a, 1);
      check_eq("up_done", dn_a, 0);
      tick();
    end
    check_eq("up_done_pulse", dn_a, 1);
    check_eq("up_done_valid", val_a, 0);
    check_eq("up_done_busy", bsy_a, 0);
    check_eq("up_done_pattern", pat_a, 0);
    tick();
    check_eq("up_after_done", dn_a, 0);
    check_eq("up_after_busy", bsy_a, 0);

    // Gray, DWELL=1; mode input changes mid-sweep and must be ignored.
    do_reset();
    pulse_start(2'b01);
    mode = 2'b11;
    for (int k = 0; k < 8; k++) begin
      check_eq("gray_pattern", pat_b, gray_tab[k]);
      check_eq("gray_index", idx_b, k);
      tick();
    end
    check_eq("gray_done", dn_b, 1);
    check_eq("gray_valid_off", val_b, 0);

    // Binary descending, DWELL=1.
    do_reset();
    pulse_start(2'b10);
    for (int k = 0; k < 8; k++) begin
      check_eq("dn_pattern", pat_b, 7 - k);
      tick();
    end
    check_eq("dn_done", dn_b, 1);

    // Walking one, DWELL=3: only three vectors.
    do_reset();
    pulse_start(2'b11);
    for (int k = 0; k < 9; k++) begin
      check_eq("walk_pattern", pat_c, walk_tab[k / 3]);
      check_eq("walk_valid", val_c, 1);
      tick();
    end
    check_eq("walk_done", dn_c, 1);
    check_eq("walk_no_fourth", val_c, 0);

    // Hold for 5 cycles while pattern=3 stretches it to 7 cycles.
    do_reset();
    pulse_start(2'b00);
    for (int k = 0; k < 6; k++) tick();
    check_eq("hold_pre", pat_a, 3);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("hold_frozen", pat_a, 3);
    end
    hold = 1'b0;
    tick();
    check_eq("hold_last3", pat_a, 3);
    tick();
    for (int k = 0; k < 8; k++) begin
      check_eq("hold_resume", pat_a, 4 + k / 2);
      tick();
    end
    check_eq("hold_done", dn_a, 1);

    // Abort at pattern 5; done must never pulse; restart from index 0.
    do_reset();
    pulse_start(2'b00);
    for (int k = 0; k < 10; k++) tick();
    check_eq("abort_pre", pat_a, 5);
    abort = 1'b1;
    hold  = 1'b1;
    tick();
    abort = 1'b0;
    hold  = 1'b0;
    check_eq("abort_pattern", pat_a, 0);
    check_eq("abort_index", idx_a, 0);
    check_eq("abort_valid", val_a, 0);
    check_eq("abort_busy", bsy_a, 0);
    check_eq("abort_done", dn_a, 0);
    tick();
    check_eq("abort_done2", dn_a, 0);
    pulse_start(2'b00);
    check_eq("restart_busy", bsy_a, 1);
    check_eq("restart_index", idx_a, 0);
    tick();
    check_eq("restart_hold0", pat_a, 0);
    tick();
    check_eq("restart_step1", pat_a, 1);

    // Asynchronous reset mid-sweep: outputs clear between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_eq("areset_pattern", pat_a, 0);
    check_eq("areset_index", idx_a, 0);
    check_eq("areset_valid", val_a, 0);
    check_eq("areset_busy", bsy_a, 0);
    #4 rst_n = 1'b1;
    tick();
    tick();
    check_eq("areset_waits", bsy_a, 0);

    // Start held through DONE is ignored there, accepted in the next IDLE.
    pulse_start(2'b00);
    for (int k = 0; k < 8; k++) tick();
    check_eq("sd_done", dn_b, 1);
    start = 1'b1;
    tick();
    check_eq("sd_ignored", bsy_b, 0);
    check_eq("sd_ignored_done", dn_b, 0);
    tick();
    start = 1'b0;
    check_eq("sd_accept", bsy_b, 1);
    check_eq("sd_accept_index", idx_b, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_sweep.md
PATTERN_SWEEP -- requirements
Module: pattern_sweep

Interface
REQ-001 Parameter WIDTH, default 3: pattern width in bits; legal range 1..16.
REQ-002 Parameter DWELL, default 4: clock cycles each vector is held; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begins a sweep when sampled high in IDLE.
REQ-006 abort  input  1  ends a sweep immediately with no done pulse.
REQ-007 hold  input  1  pauses the sweep: pattern, index and dwell count freeze.
REQ-008 mode  input  2  sequence select; latched at start.
REQ-009 pattern  output  WIDTH  current stimulus vector, registered.
REQ-010 index  output  WIDTH  ordinal of the current vector, starting at 0.
REQ-011 valid  output  1  high while pattern carries a sweep vector.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse after the final vector completes.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-015 IDLE to RUN: start=1 and abort=0 at the edge; mode is latched and index=0 on the next cycle, with valid=1 and busy=1.
REQ-016 Each vector SHALL stay on pattern for exactly DWELL cycles in which hold=0; hold=1 cycles are not counted.
REQ-017 Mode 00 (binary ascending): pattern=index, vector count N=2^WIDTH.
REQ-018 Mode 01 (Gray): pattern=index^(index>>1), N=2^WIDTH.
REQ-019 Mode 10 (binary descending): pattern=~index (2^WIDTH-1-index), N=2^WIDTH.
REQ-020 Mode 11 (walking one): pattern=1<<index, N=WIDTH.
REQ-021 Pattern and index SHALL update on the same edge, with no intermediate values.
REQ-022 Index SHALL be compared against N-1 without overflow; when WIDTH bits are full, the last-vector test SHALL NOT rely on index wrapping to 0.
REQ-023 After the DWELL-th counted cycle of vector N-1, the FSM SHALL enter DONE: valid=0, busy=0, done=1 for one cycle, then return to IDLE.
REQ-024 start during RUN or DONE SHALL be ignored; start in the IDLE cycle that follows DONE SHALL be accepted.
REQ-025 abort=1 in RUN or DONE SHALL force IDLE on the next edge: valid=0, busy=0, done=0, pattern=0, index=0; abort has priority over hold and start.
REQ-026 hold in IDLE or DONE SHALL have no effect.
REQ-027 Changes on mode during RUN SHALL NOT affect the sweep in progress.
REQ-028 In IDLE, pattern and index SHALL read 0.

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0, the state SHALL be IDLE, and the dwell counter and latched mode SHALL be 0, independent of clk.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep; after release, the block waits for a new start.
REQ-031 Reset release SHALL take effect at the first clk edge at which rst_n=1.

Structure
REQ-032 Shared package sweep_pkg SHALL hold the mode encodings (MODE_BIN_UP, MODE_GRAY, MODE_BIN_DN, MODE_WALK1) and the FSM state encodings.
REQ-033 Pattern generation SHALL be a combinational sub-module sweep_encode (index, mode -> pattern); the counters and FSM remain in pattern_sweep.
REQ-034 The dwell counter width SHALL be $clog2(DWELL+1) bits.

Verification
REQ-035 WIDTH=3, DWELL=2, mode=00, start pulse: pattern 0,1,...,7, each for 2 cycles; valid high for 16 cycles; done pulses once in the following cycle; busy is low afterwards.
REQ-036 WIDTH=3, DWELL=1, mode=01: pattern sequence 000,001,011,010,110,111,101,100, then done; mode=10 gives 111 down to 000.
REQ-037 WIDTH=3, DWELL=3, mode=11: pattern 001,010,100 for 3 cycles each, then done; no fourth vector appears.
REQ-038 WIDTH=3, DWELL=2, mode=00, hold=1 for 5 cycles while pattern=3: pattern stays 3 for 7 cycles in total; the sweep then completes normally.
REQ-039 abort asserted while pattern=5: next cycle pattern=0, valid=0, busy=0, and done never pulses; a start 2 cycles later restarts from index 0.
REQ-040 rst_n pulsed low asynchronously mid-sweep: outputs go to 0 without waiting for a clk edge; start asserted during DONE is ignored and start in the following IDLE cycle is accepted.
